// File: rtl/rx_pkg.sv
// Shared receive-path types and widths.
// Also used by the transmitter for SAMPLE_W.
package rx_pkg;

    typedef enum logic {
        IDLE,
        INTEG
    } state_t;

    localparam int SAMPLE_W = 16;

    // Accumulator width that holds SPS full-scale samples without overflow
    function automatic int acc_width(input int sps);
        return SAMPLE_W + $clog2(sps);
    endfunction

endpackage

// File: rtl/bpsk_receiver_int_dump.sv
// Signed integrate-and-dump accumulator with symbol counter.
// sum is the running total including the sample now presented.
module int_dump
    import rx_pkg::*;
#(
    parameter int SPS   = 8,
    parameter int ACC_W = acc_width(SPS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      add_en,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic signed [ACC_W-1:0]   sum,
    output logic                      done
);

    localparam int CNT_W = $clog2(SPS);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sample_x;
    logic [CNT_W-1:0]        cnt;

    assign sample_x = {{(ACC_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
    assign sum      = acc + sample_x;
    assign done     = add_en && (cnt == CNT_W'(SPS - 1));

    // Accumulate valid samples; empty on symbol completion or abort
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear || done) begin
            acc <= '0;
            cnt <= '0;
        end else if (add_en) begin
            acc <= sum;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bpsk_receiver.sv
// Integrate-and-dump BPSK receiver with hard slicer and
// a one-entry valid/ready output register.
module bpsk_receiver
    import rx_pkg::*;
#(
    parameter int SPS   = 8,
    parameter int ACC_W = acc_width(SPS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] rx_in,
    input  logic                       rx_valid,
    output logic                       bit_out,
    output logic signed [ACC_W-1:0]    soft_out,
    output logic                       bit_valid,
    input  logic                       bit_ready,
    output logic                       sym_err,
    output logic                       overrun
);

    state_t                  state;
    logic                    clear;
    logic                    done;
    logic                    hard;
    logic signed [ACC_W-1:0] sum;

    assign clear = (state == INTEG) && !rx_valid;
    assign hard  = !sum[ACC_W-1] && (sum != '0);

    int_dump #(
        .SPS   (SPS),
        .ACC_W (ACC_W)
    ) u_int_dump (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .add_en (rx_valid),
        .sample (rx_in),
        .sum    (sum),
        .done   (done)
    );

    // Symbol framing FSM; flags a partial symbol cut short
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            sym_err <= 1'b0;
        end else begin
            sym_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rx_valid)
                        state <= INTEG;
                end
                INTEG: begin
                    if (!rx_valid) begin
                        state   <= IDLE;
                        sym_err <= 1'b1;
                    end else if (done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: load on completion when free, else flag overrun
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_out   <= 1'b0;
            soft_out  <= '0;
            bit_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (done) begin
            if (!bit_valid || bit_ready) begin
                bit_out   <= hard;
                soft_out  <= sum;
                bit_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (bit_valid && bit_ready) begin
            bit_valid <= 1'b0;
        end
    end

endmodule

// File: doc/bpsk_receiver.md
# bpsk_receiver

Integrate-and-dump BPSK receiver at the far end of the channel from the transmitter. It accepts the signed 16-bit square-pulse sample stream qualified by the transmitter's ready strobe, and sums SPS consecutive samples per symbol. It slices the sum into a hard bit and presents the bit, with its soft value, on a one-entry valid/ready output register to the downstream decoder.

## Interface
- SPS, default 8: samples per symbol; must be a power of two, range 2–64.
- ACC_W, default 16+$clog2(SPS): accumulator and soft-value width; must not be overridden below this value.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_in  in  16  signed channel sample. Driven by transmitter trans_out.
- rx_valid  in  1  sample qualifier. Driven by transmitter trans_rdy.
- bit_out  out  1  hard decision: 1 when soft_out > 0, otherwise 0.
- soft_out  out  ACC_W  signed integrated symbol value.
- bit_valid  out  1  bit_out and soft_out hold an unconsumed symbol.
- bit_ready  in  1  downstream accepts the symbol.
- sym_err  out  1  one-cycle pulse: a partial symbol was discarded because rx_valid dropped mid-symbol.
- overrun  out  1  sticky flag: a completed symbol was dropped because the output register was full. Cleared only by reset.

## Operation
- States: IDLE, INTEG.
- IDLE:
  - The accumulator is 0 and the sample counter is 0.
  - When rx_valid=1, load acc=sext(rx_in), set cnt=1 and go to INTEG.
- INTEG, when rx_valid=1:
  - acc += sext(rx_in) and cnt++.
  - On the sample that makes cnt==SPS, the symbol completes: the final sum (including that sample) goes to the output stage, acc and cnt clear, and the state returns to IDLE.
  - If rx_valid is also high on the following cycle, that sample starts the next symbol from IDLE with no gap.
- INTEG, when rx_valid=0: discard the partial sum, pulse sym_err, clear acc and cnt, return to IDLE.
- Arithmetic:
  - Two's-complement with sign extension to ACC_W. No saturation; ACC_W guarantees no overflow.
  - Full-scale range is SPS·(−32768) … SPS·32767.
- Decision: bit = (sum > 0). A sum of exactly 0 resolves to 0.
- Output stage, when a symbol completes:
  - If bit_valid=0, or bit_valid=1 with bit_ready=1 in the same cycle: load soft_out and bit_out, and bit_valid=1.
  - If bit_valid=1 with bit_ready=0: drop the new symbol, set overrun=1, and leave the held symbol unchanged.
- Output stage, no completion: bit_valid=1 with bit_ready=1 clears bit_valid.
- SPS=1 is not supported.

## Timing
- Reset values (asynchronous, while reset=0): bit_out=0, soft_out=0, bit_valid=0, sym_err=0, overrun=0, state=IDLE, acc=0, cnt=0.
- Reset mid-symbol discards the partial symbol and any held output. No sym_err is generated.
- Latency: bit_valid rises on the clock edge that samples the SPS-th valid sample. Outputs are visible the cycle after that sample is presented.
- Throughput: one symbol per SPS cycles at continuous rx_valid. With an always-ready consumer, bit_valid pulses for 1 cycle every SPS cycles.
- sym_err is registered and asserts the cycle after the edge that sampled rx_valid=0 in INTEG.
- bit_out and soft_out are stable while bit_valid=1 and bit_ready=0.

## Structure
- Shared package rx_pkg:
  - state enum {IDLE, INTEG};
  - localparam SAMPLE_W=16;
  - function acc_width(sps) returning SAMPLE_W+$clog2(sps).
- The transmitter uses SAMPLE_W from the same package.
- One sub-module, int_dump: signed accumulator plus symbol counter, with ports
  - inputs: clear, add_en, sample;
  - outputs: sum, done.
- bpsk_receiver holds the FSM, slicer, output register, and the flags.

## Test plan
- SPS=8, 8 consecutive samples of +1000 with bit_ready=1 → soft_out=8000, bit_out=1, bit_valid high for exactly 1 cycle, 8 cycles after the first sample.
- 8 samples of −32768 → soft_out=−262144 (ACC_W=19, no wrap), bit_out=0. Then 8 samples of +32767 → soft_out=262136, bit_out=1, back-to-back with no gap cycle.
- Alternating +500/−500 ×8 → soft_out=0, bit_out=0.
- 5 valid samples of +1000, then rx_valid=0 → sym_err pulses once and no bit_valid. The next 8 samples of −200 → soft_out=−1600, bit_out=0.
- bit_ready=0 while two full symbols (+100 ×8, then −100 ×8) arrive:
  - first symbol held (soft_out=800) and overrun=1 after the second completes;
  - bit_ready=1 then clears bit_valid, and overrun stays 1 until reset.
- reset=0 asserted asynchronously after 4 samples of a symbol → all outputs 0 immediately. After release, 8 samples of +1 → soft_out=8, bit_out=1.
